// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM request arbiter: control-interface commands,
// arbiter FSM states and grant owner.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'b000,
    CMD_READA   = 3'b001,
    CMD_WRITEA  = 3'b010,
    CMD_REFRESH = 3'b011
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_A   = 2'd0,
    GNT_B   = 2'd1,
    GNT_REF = 2'd2
  } grant_e;

  function automatic cmd_e rw_cmd(input logic wr);
    return wr ? CMD_WRITEA : CMD_READA;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Counts cycles while enabled; expired is high during the TIMEOUT-th enabled
// cycle after a clear.
module arb_timeout_cnt
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of enabled cycles already completed
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates refresh and two user requesters onto one SDRAM command port.
// Define ARB_ROUND_ROBIN_EN for A/B round-robin; otherwise A has fixed priority.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ASIZE   = 23,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INIT_REQ,
  input  logic             REF_REQ,
  input  logic             A_REQ,
  input  logic             B_REQ,
  input  logic             A_WR,
  input  logic             B_WR,
  input  logic [ASIZE-1:0] A_ADDR,
  input  logic [ASIZE-1:0] B_ADDR,
  input  logic             CMD_ACK,
  output logic [2:0]       CMD,
  output logic [ASIZE-1:0] ADDR,
  output logic             A_ACK,
  output logic             B_ACK,
  output logic             REF_ACK,
  output logic             ERR
);

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  grant_e           grant_q, grant_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic             a_ack_q, a_ack_d;
  logic             b_ack_q, b_ack_d;
  logic             ref_ack_q, ref_ack_d;
  logic             err_q, err_d;
  logic             pick_b;
  logic             tmo_expired;

`ifdef ARB_ROUND_ROBIN_EN
  // last_b_q: B was the last requester to complete, so A wins a tie next
  logic last_b_q, last_b_d;
  assign pick_b = B_REQ && (!A_REQ || !last_b_q);
`else
  assign pick_b = B_REQ && !A_REQ;
`endif

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (state_q != ST_ISSUE),
    .en      (state_q == ST_ISSUE),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    grant_d   = grant_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    ref_ack_d = 1'b0;
    err_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_b_d  = last_b_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_d = CMD_NOP;
        if (!INIT_REQ) begin
          if (REF_REQ) begin
            cmd_d   = CMD_REFRESH;
            addr_d  = '0;
            grant_d = GNT_REF;
            state_d = ST_ISSUE;
          end else if (A_REQ || B_REQ) begin
            if (pick_b) begin
              cmd_d   = rw_cmd(B_WR);
              addr_d  = B_ADDR;
              grant_d = GNT_B;
            end else begin
              cmd_d   = rw_cmd(A_WR);
              addr_d  = A_ADDR;
              grant_d = GNT_A;
            end
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // A late ack in the expiry cycle still completes the command
        if (CMD_ACK) begin
          cmd_d   = CMD_NOP;
          state_d = ST_DONE;
          case (grant_q)
            GNT_A: begin
              a_ack_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
              last_b_d = 1'b0;
`endif
            end
            GNT_B: begin
              b_ack_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
              last_b_d = 1'b1;
`endif
            end
            default: ref_ack_d = 1'b1;
          endcase
        end else if (tmo_expired) begin
          cmd_d   = CMD_NOP;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        cmd_d   = CMD_NOP;
        state_d = ST_IDLE;
      end
      default: begin
        cmd_d   = CMD_NOP;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      grant_q   <= GNT_A;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      ref_ack_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      grant_q   <= grant_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      ref_ack_q <= ref_ack_d;
      err_q     <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

  assign CMD     = cmd_q;
  assign ADDR    = addr_q;
  assign A_ACK   = a_ack_q;
  assign B_ACK   = b_ack_q;
  assign REF_ACK = ref_ack_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: reset, single read, A/B arbitration,
// refresh priority, init hold-off, timeout abort and reset during a command.
module tb_sdram_req_arbiter;

  localparam int ASIZE = 23;

  logic             CLK      = 1'b0;
  logic             RESET    = 1'b0;
  logic             INIT_REQ = 1'b0;
  logic             REF_REQ  = 1'b0;
  logic             A_REQ    = 1'b0;
  logic             B_REQ    = 1'b0;
  logic             A_WR     = 1'b0;
  logic             B_WR     = 1'b0;
  logic [ASIZE-1:0] A_ADDR   = '0;
  logic [ASIZE-1:0] B_ADDR   = '0;
  logic             CMD_ACK  = 1'b0;
  logic [2:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             A_ACK, B_ACK, REF_ACK, ERR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sdram_req_arbiter #(.ASIZE(ASIZE), .TIMEOUT(255)) dut (
    .CLK(CLK), .RESET(RESET), .INIT_REQ(INIT_REQ), .REF_REQ(REF_REQ),
    .A_REQ(A_REQ), .B_REQ(B_REQ), .A_WR(A_WR), .B_WR(B_WR),
    .A_ADDR(A_ADDR), .B_ADDR(B_ADDR), .CMD_ACK(CMD_ACK),
    .CMD(CMD), .ADDR(ADDR), .A_ACK(A_ACK), .B_ACK(B_ACK),
    .REF_ACK(REF_ACK), .ERR(ERR)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1; INIT_REQ = 1'b0; REF_REQ = 1'b0; A_REQ = 1'b0; B_REQ = 1'b0;
    A_WR = 1'b0; B_WR = 1'b0; A_ADDR = '0; B_ADDR = '0; CMD_ACK = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    RESET = 1'b1;
    #1;
    total++;
    if (CMD !== 3'd0) begin bad++; $display("FAIL reset_cmd: got %0h want 0", CMD); end
    total++;
    if (ADDR !== '0) begin bad++; $display("FAIL reset_addr: got %0h want 0", ADDR); end
    total++;
    if ({A_ACK, B_ACK, REF_ACK, ERR} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {A_ACK, B_ACK, REF_ACK, ERR});
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 23'h000123;
    tick();
    total++;
    if (CMD !== 3'd1 || ADDR !== 23'h000123) begin
      bad++; $display("FAIL rd_issue: got cmd=%0h addr=%0h want cmd=1 addr=123", CMD, ADDR);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (CMD !== 3'd1 || ADDR !== 23'h000123 || A_ACK !== 1'b0) begin
        bad++; $display("FAIL rd_hold%0d: got cmd=%0h addr=%0h ack=%b want cmd=1 addr=123 ack=0",
                        i, CMD, ADDR, A_ACK);
      end
    end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0; A_REQ = 1'b0;
    total++;
    if ({CMD, A_ACK, B_ACK, REF_ACK, ERR} !== {3'd0, 4'b1000}) begin
      bad++; $display("FAIL rd_ack: got cmd=%0h flags=%b want cmd=0 flags=1000",
                      CMD, {A_ACK, B_ACK, REF_ACK, ERR});
    end
    tick();
    total++;
    if (A_ACK !== 1'b0 || CMD !== 3'd0) begin
      bad++; $display("FAIL rd_ack_pulse: got ack=%b cmd=%0h want ack=0 cmd=0", A_ACK, CMD);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_b [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    apply_reset();
    A_REQ = 1'b1; B_REQ = 1'b1; A_WR = 1'b0; B_WR = 1'b1;
    A_ADDR = 23'h000111; B_ADDR = 23'h000222;
    for (int g = 0; g < 4; g++) begin
      int waited;
      tick();
      waited = 1;
      while (CMD === 3'd0 && waited < 10) begin
        tick();
        waited++;
      end
      total++;
      if (waited !== ((g == 0) ? 1 : 2)) begin
        bad++; $display("FAIL rr_gap%0d: got %0d cycles want %0d", g, waited, (g == 0) ? 1 : 2);
      end
      total++;
      if (CMD !== (exp_b[g] ? 3'd2 : 3'd1) || ADDR !== (exp_b[g] ? 23'h000222 : 23'h000111)) begin
        bad++; $display("FAIL rr_grant%0d: got cmd=%0h addr=%0h want %s", g, CMD, ADDR,
                        exp_b[g] ? "B" : "A");
      end
      tick();
      CMD_ACK = 1'b1;
      tick();
      CMD_ACK = 1'b0;
      total++;
      if ({CMD, A_ACK, B_ACK} !== {3'd0, exp_b[g] ? 2'b01 : 2'b10}) begin
        bad++; $display("FAIL rr_ack%0d: got cmd=%0h a=%b b=%b want %s ack", g, CMD, A_ACK, B_ACK,
                        exp_b[g] ? "B" : "A");
      end
    end
    A_REQ = 1'b0; B_REQ = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ref_priority();
    apply_reset();
    REF_REQ = 1'b1; B_REQ = 1'b1; B_WR = 1'b1; B_ADDR = 23'h0ABCDE;
    tick();
    total++;
    if (CMD !== 3'd3 || ADDR !== '0) begin
      bad++; $display("FAIL ref_first: got cmd=%0h addr=%0h want cmd=3 addr=0", CMD, ADDR);
    end
    tick();
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0; REF_REQ = 1'b0;
    total++;
    if ({CMD, REF_ACK, A_ACK, B_ACK} !== {3'd0, 3'b100}) begin
      bad++; $display("FAIL ref_ack: got cmd=%0h ref/a/b=%b want cmd=0 100",
                      CMD, {REF_ACK, A_ACK, B_ACK});
    end
    tick();
    tick();
    total++;
    if (CMD !== 3'd2 || ADDR !== 23'h0ABCDE) begin
      bad++; $display("FAIL ref_then_b: got cmd=%0h addr=%0h want cmd=2 addr=abcde", CMD, ADDR);
    end
    // B withdraws and refresh arrives mid-command: B still completes, refresh waits
    B_REQ = 1'b0; REF_REQ = 1'b1;
    tick();
    total++;
    if (CMD !== 3'd2) begin bad++; $display("FAIL b_held: got cmd=%0h want 2", CMD); end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    total++;
    if ({CMD, REF_ACK, A_ACK, B_ACK} !== {3'd0, 3'b001}) begin
      bad++; $display("FAIL b_ack: got cmd=%0h ref/a/b=%b want cmd=0 001",
                      CMD, {REF_ACK, A_ACK, B_ACK});
    end
    tick();
    tick();
    total++;
    if (CMD !== 3'd3) begin bad++; $display("FAIL ref_waited: got cmd=%0h want 3", CMD); end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0; REF_REQ = 1'b0;
    total++;
    if (REF_ACK !== 1'b1) begin bad++; $display("FAIL ref_ack2: got %b want 1", REF_ACK); end
    tick();
    tick();
  endtask

  task automatic test_init_hold();
    apply_reset();
    INIT_REQ = 1'b1; A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 23'h000456;
    for (int i = 0; i < 50; i++) begin
      CMD_ACK = (i >= 10 && i < 15);
      tick();
      total++;
      if ({CMD, A_ACK, B_ACK, REF_ACK} !== 6'd0) begin
        bad++; $display("FAIL init_hold%0d: got cmd=%0h acks=%b want 0", i, CMD,
                        {A_ACK, B_ACK, REF_ACK});
      end
    end
    CMD_ACK = 1'b0; INIT_REQ = 1'b0;
    tick();
    total++;
    if (CMD !== 3'd1 || ADDR !== 23'h000456) begin
      bad++; $display("FAIL init_release: got cmd=%0h addr=%0h want cmd=1 addr=456", CMD, ADDR);
    end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0; A_REQ = 1'b0;
    total++;
    if (A_ACK !== 1'b1) begin bad++; $display("FAIL init_ack: got %b want 1", A_ACK); end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int held;
    apply_reset();
    A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 23'h000789;
    tick();
    total++;
    if (CMD !== 3'd1) begin bad++; $display("FAIL tmo_issue: got cmd=%0h want 1", CMD); end
    held = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (CMD === 3'd1 && ERR === 1'b0 && A_ACK === 1'b0) held++;
    end
    total++;
    if (held !== 254) begin bad++; $display("FAIL tmo_hold: got %0d cycles want 254", held); end
    // B now competes too; the aborted grant must not move the pointer, so A wins again
    B_REQ = 1'b1; B_WR = 1'b1; B_ADDR = 23'h000055;
    tick();
    total++;
    if ({CMD, ERR, A_ACK, B_ACK} !== {3'd0, 3'b100}) begin
      bad++; $display("FAIL tmo_err: got cmd=%0h err/a/b=%b want cmd=0 100",
                      CMD, {ERR, A_ACK, B_ACK});
    end
    tick();
    total++;
    if (CMD !== 3'd1 || ADDR !== 23'h000789 || ERR !== 1'b0) begin
      bad++; $display("FAIL tmo_reissue: got cmd=%0h addr=%0h err=%b want cmd=1 addr=789 err=0",
                      CMD, ADDR, ERR);
    end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0; A_REQ = 1'b0; B_REQ = 1'b0;
    total++;
    if (A_ACK !== 1'b1) begin bad++; $display("FAIL tmo_ack: got %b want 1", A_ACK); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    B_REQ = 1'b1; B_WR = 1'b1; B_ADDR = 23'h000333;
    tick();
    total++;
    if (CMD !== 3'd2) begin bad++; $display("FAIL mid_issue: got cmd=%0h want 2", CMD); end
    tick();
    #2;
    RESET = 1'b1;
    #1;
    total++;
    if (CMD !== 3'd0 || ADDR !== '0) begin
      bad++; $display("FAIL mid_async: got cmd=%0h addr=%0h want 0 0", CMD, ADDR);
    end
    A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 23'h000444; CMD_ACK = 1'b1;
    tick();
    total++;
    if ({CMD, A_ACK, B_ACK} !== 5'd0) begin
      bad++; $display("FAIL mid_held: got cmd=%0h a=%b b=%b want 0", CMD, A_ACK, B_ACK);
    end
    CMD_ACK = 1'b0; RESET = 1'b0;
    tick();
    total++;
    if (CMD !== 3'd1 || ADDR !== 23'h000444) begin
      bad++; $display("FAIL mid_a_wins: got cmd=%0h addr=%0h want cmd=1 addr=444", CMD, ADDR);
    end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0; A_REQ = 1'b0; B_REQ = 1'b0;
    total++;
    if ({A_ACK, B_ACK} !== 2'b10) begin
      bad++; $display("FAIL mid_ack: got a/b=%b want 10", {A_ACK, B_ACK});
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_ref_priority();
    test_init_hold();
    test_timeout();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
